// File: rtl/serial_mag_comparator_ctrl.sv
// Serial N-bit unsigned magnitude comparator: one 1-bit slice walked MSB-first under a start/done
// handshake. Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit.
module serial_mag_comparator_ctrl #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IdxW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt,
  output logic [IdxW-1:0]  bit_idx
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic ai, bi, slice_l, slice_g, decided, new_lt, new_gt, exit_run;

  assign ai      = a_q[idx_q];
  assign bi      = b_q[idx_q];
  assign slice_l = ~ai & bi;
  assign slice_g = ai & ~bi;
  assign decided = lt_q | gt_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;
    busy     = 1'b0;
    done     = 1'b0;
    new_lt   = lt_q;
    new_gt   = gt_q;
    exit_run = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IdxW'(WIDTH - 1);
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        busy = 1'b1;
        // The most significant differing bit wins; later differences are ignored.
        if (!decided) begin
          new_lt = slice_l;
          new_gt = slice_g;
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        exit_run = (idx_q == '0) || (!decided && (slice_l || slice_g));
`else
        exit_run = (idx_q == '0);
`endif
        lt_d = new_lt;
        gt_d = new_gt;
        if (exit_run) begin
          eq_d    = ~(new_lt | new_gt);
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  assign lt      = lt_q;
  assign eq      = eq_q;
  assign gt      = gt_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_serial_mag_comparator_ctrl.sv
// Self-checking bench for serial_mag_comparator_ctrl (WIDTH=8), directed plus random operands
// against an arithmetic reference; honours SERIAL_CMP_EARLY_EXIT_EN for latency expectations.
module tb_serial_mag_comparator_ctrl;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, lt, eq, gt;
  logic [2:0]   bit_idx;

  int n_checks = 0;
  int n_fail   = 0;

  serial_mag_comparator_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .lt      (lt),
    .eq      (eq),
    .gt      (gt),
    .bit_idx (bit_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RUN cycles the reference expects before DONE.
  function automatic int exp_lat(input logic [W-1:0] av, input logic [W-1:0] bv);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) if (av[i] != bv[i]) return W - i;
`endif
    return W;
  endfunction

  task automatic do_cmp(input logic [W-1:0] av, input logic [W-1:0] bv, input string tag);
    int cycles;
    logic [2:0] res;
    res = (av < bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    cycles = 1;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_flags_clear"}, {29'd0, lt, eq, gt}, 32'd0);
    check({tag, "_idx_start"}, {29'd0, bit_idx}, W - 1);
    while (!done && cycles < 40) begin
      step();
      cycles++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_latency"}, cycles, exp_lat(av, bv) + 1);
    check({tag, "_result"}, {29'd0, lt, eq, gt}, {29'd0, res});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_held"}, {29'd0, lt, eq, gt}, {29'd0, res});
    check({tag, "_idx_hold"}, {29'd0, bit_idx}, 32'd0);
  endtask

  initial begin
    int n_done;
    int cyc;
    bit prev_done;
    int dpos[$];
    logic [W-1:0] rb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    check("reset_state", {26'd0, busy, done, lt, eq, gt, bit_idx}, 32'd0);

    do_cmp(8'hA5, 8'hA5, "eq_a5");
    do_cmp(8'h80, 8'h7F, "gt_msb");
    do_cmp(8'h00, 8'h00, "eq_zero");
    do_cmp(8'hFF, 8'hFF, "eq_ones");
    do_cmp(8'h01, 8'h00, "gt_bit0");

    // Re-issued start and operand changes during RUN must be ignored.
    a = 8'h10; b = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; a = 8'hFF;
    step(); step(); step();
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        n_done++;
        check("midrun_result", {29'd0, lt, eq, gt}, 32'b100);
      end
      step();
    end
    check("midrun_done_once", n_done, 32'd1);
    check("midrun_idle", {31'd0, busy}, 32'd0);

    // Reset during RUN at bit_idx 4.
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    rb = 8'h0F;
`else
    rb = 8'hFF;
`endif
    a = 8'h00; b = rb; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (bit_idx != 3'd4 && cyc < 12) begin
      step();
      cyc++;
    end
    check("rst_run_at_idx4", {28'd0, busy, bit_idx}, 32'h0C);
    #2 rst_n = 1'b0;
    #1 check("rst_async", {26'd0, busy, done, lt, eq, gt, bit_idx}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) n_done++;
    end
    check("rst_no_done", n_done, 32'd0);
    do_cmp(8'h00, 8'hFF, "after_rst_lt");

    for (int i = 0; i < 16; i++) do_cmp(W'($urandom), W'($urandom), "rand");

    // Start held high: one compare per W+2 cycles, never accepted during DONE.
    a = 8'h03; b = 8'h02; start = 1'b1;
    prev_done = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      step();
      if (prev_done) check("b2b_no_accept_in_done", {31'd0, busy}, 32'd0);
      if (done) begin
        dpos.push_back(i);
        check("b2b_result", {29'd0, lt, eq, gt}, 32'b001);
      end
      prev_done = done;
    end
    start = 1'b0;
    check("b2b_count", dpos.size(), 32'd3);
    foreach (dpos[k]) check("b2b_spacing", dpos[k], W + 1 + k * (W + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
